// File: rtl/cam_dvp_capture_pkg.sv
// rtl/cam_dvp_capture_pkg.sv - shared state encoding and width helper for the DVP capture front-end
package cam_dvp_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_STOPPING = 2'd3
  } cap_state_t;

  // Counter width able to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_dvp_capture_if.sv
// rtl/cam_dvp_capture_if.sv - packed pixel word stream with frame/line tags
interface cam_dvp_capture_if #(
  parameter int OUT_W = 64
) ();

  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_sof;
  logic             dout_eol;

  modport master (output dout, dout_valid, dout_sof, dout_eol, input dout_ready);
  modport slave  (input dout, dout_valid, dout_sof, dout_eol, output dout_ready);

endinterface

// File: rtl/cam_dvp_capture_pix_packer.sv
// rtl/cam_dvp_capture_pix_packer.sv - packs kept pixels into tagged words and buffers them in a 2-entry FIFO
module cam_dvp_capture_pix_packer
  import cam_dvp_capture_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int OUT_W = 64
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  input  logic             line_end,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_sof,
  output logic             dout_eol,
  output logic             err_ovf
);

  localparam int PPW = OUT_W / PIX_W;
  localparam int CW  = cnt_width(PPW);

  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sof_pend;
  logic [OUT_W+1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;

  logic [OUT_W-1:0] word_next;
  logic             push;
  logic             push_eol;
  logic             pop;
  logic             push_ok;

  assign dout_valid = (count != 2'd0);
  assign dout       = mem[rptr][OUT_W-1:0];
  assign dout_eol   = mem[rptr][OUT_W];
  assign dout_sof   = mem[rptr][OUT_W+1];

  always_comb begin
    word_next = acc;
    for (int i = 0; i < PPW; i++) begin
      if (pix_valid && cnt == CW'(i)) word_next[i*PIX_W +: PIX_W] = pix_data;
    end
    push     = 1'b0;
    push_eol = 1'b0;
    if (pix_valid) begin
      push     = pix_last || (cnt == CW'(PPW-1));
      push_eol = pix_last;
    end else if (line_end && cnt != '0) begin
      // Line ended before the crop's right edge: flush the partial word.
      push     = 1'b1;
      push_eol = 1'b1;
    end
    pop     = dout_valid && dout_ready;
    push_ok = push && ((count != 2'd2) || pop);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sof_pend <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
      err_ovf  <= 1'b0;
    end else begin
      if (push) begin
        acc      <= '0;
        cnt      <= '0;
        sof_pend <= 1'b0;
      end else if (pix_valid) begin
        acc <= word_next;
        cnt <= cnt + CW'(1);
      end
      // A line closed by the vsync edge flushes first; the new frame then starts clean.
      if (frame_start) begin
        acc      <= '0;
        cnt      <= '0;
        sof_pend <= 1'b1;
      end
      if (push_ok) begin
        mem[wptr] <= {sof_pend, push_eol, word_next};
        wptr      <= ~wptr;
      end
      if (push && !push_ok) err_ovf <= 1'b1;
      if (pop) rptr <= ~rptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// rtl/cam_dvp_capture.sv - DVP camera front-end: pin registers, control FSM, pixel assembly, crop and stats
module cam_dvp_capture
  import cam_dvp_capture_pkg::*;
#(
  parameter int DIN_W     = 8,
  parameter int BPP       = 2,
  parameter int OUT_W     = 64,
  parameter int CNT_W     = 12,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] din,
  input  logic             vsync,
  input  logic             href,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] crop_x0,
  input  logic [CNT_W-1:0] crop_x1,
  input  logic [CNT_W-1:0] crop_y0,
  input  logic [CNT_W-1:0] crop_y1,
  cam_dvp_capture_if.master stream,
  output logic             running,
  output logic [31:0]      frame_cnt,
  output logic [CNT_W-1:0] last_rows,
  output logic             err_ovf,
  output logic             err_beat
);

  localparam int PIX_W = DIN_W * BPP;
  localparam int BW    = cnt_width(BPP);

  cap_state_t       state;
  logic [DIN_W-1:0] din_r;
  logic             vsync_r;
  logic             vsync_q;
  logic             href_r;
  logic             href_q;
  logic [BW-1:0]    beat;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [PIX_W-1:0] pix_acc;

  logic             frame_start;
  logic             frame_end;
  logic             line_end;
  logic             beat_en;
  logic             pix_done;
  logic [PIX_W-1:0] pix_full;
  logic             pix_keep;
  logic             pix_last;
  logic [CNT_W-1:0] row_done;

  always_comb begin
    frame_start = (vsync_q == VSYNC_POL) && (vsync_r != VSYNC_POL);
    frame_end   = (vsync_q != VSYNC_POL) && (vsync_r == VSYNC_POL);
    // A vsync edge inside an active line closes that line first.
    line_end    = href_q && (!href_r || frame_start || frame_end);
    beat_en     = href_r && !line_end;
    pix_done    = beat_en && (beat == BW'(BPP-1));
    pix_full    = (pix_acc << DIN_W) | PIX_W'(din_r);
    pix_keep    = pix_done && (state == ST_CAPTURE || state == ST_STOPPING)
                  && (col >= crop_x0) && (col <= crop_x1)
                  && (row >= crop_y0) && (row <= crop_y1);
    pix_last    = (col == crop_x1);
    row_done    = line_end ? row + CNT_W'(1) : row;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      din_r    <= '0;
      vsync_r  <= VSYNC_POL;
      vsync_q  <= VSYNC_POL;
      href_r   <= 1'b0;
      href_q   <= 1'b0;
      beat     <= '0;
      col      <= '0;
      row      <= '0;
      pix_acc  <= '0;
      err_beat <= 1'b0;
    end else begin
      din_r   <= din;
      vsync_r <= vsync;
      href_r  <= href;
      vsync_q <= vsync_r;
      href_q  <= href_r;
      if (beat_en) begin
        beat    <= pix_done ? '0 : beat + BW'(1);
        pix_acc <= pix_full;
      end
      if (pix_done && col != '1) col <= col + CNT_W'(1);
      if (line_end) begin
        row  <= row + CNT_W'(1);
        col  <= '0;
        beat <= '0;
        if (beat != '0) err_beat <= 1'b1;
      end
      if (frame_start) begin
        row  <= '0;
        col  <= '0;
        beat <= '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      frame_cnt <= '0;
      last_rows <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state   <= ST_ARMED;
            running <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end else if (frame_start) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (frame_end) begin
            frame_cnt <= frame_cnt + 32'd1;
            last_rows <= row_done;
            if (stop) begin
              state   <= ST_IDLE;
              running <= 1'b0;
            end
          end else if (stop) begin
            state <= ST_STOPPING;
          end
        end
        default: begin
          if (frame_end) begin
            frame_cnt <= frame_cnt + 32'd1;
            last_rows <= row_done;
            state     <= ST_IDLE;
            running   <= 1'b0;
          end
        end
      endcase
    end
  end

  cam_dvp_capture_pix_packer #(
    .PIX_W (PIX_W),
    .OUT_W (OUT_W)
  ) u_packer (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_keep),
    .pix_data    (pix_full),
    .pix_last    (pix_last),
    .line_end    (line_end),
    .dout        (stream.dout),
    .dout_valid  (stream.dout_valid),
    .dout_ready  (stream.dout_ready),
    .dout_sof    (stream.dout_sof),
    .dout_eol    (stream.dout_eol),
    .err_ovf     (err_ovf)
  );

endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb/tb_cam_dvp_capture.sv - scoreboard bench for the DVP capture front-end
module tb_cam_dvp_capture;

  localparam int OUT_W = 64;
  localparam int CNT_W = 12;

  logic             pclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       din = '0;
  logic             vsync = 1'b1;
  logic             href = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] crop_x0 = '0;
  logic [CNT_W-1:0] crop_x1 = '0;
  logic [CNT_W-1:0] crop_y0 = '0;
  logic [CNT_W-1:0] crop_y1 = '0;
  logic             running;
  logic [31:0]      frame_cnt;
  logic [CNT_W-1:0] last_rows;
  logic             err_ovf;
  logic             err_beat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [OUT_W+1:0] exp_q [$];

  localparam logic [63:0] PW_A = 64'hDEF09ABC56781234;
  localparam logic [63:0] PW_B = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] PW_C = 64'hA5A55A5AC3C33C3C;

  cam_dvp_capture_if #(.OUT_W(OUT_W)) stream ();

  always #5 pclk = ~pclk;

  cam_dvp_capture #(
    .DIN_W(8), .BPP(2), .OUT_W(OUT_W), .CNT_W(CNT_W), .VSYNC_POL(1'b1)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .din       (din),
    .vsync     (vsync),
    .href      (href),
    .start     (start),
    .stop      (stop),
    .crop_x0   (crop_x0),
    .crop_x1   (crop_x1),
    .crop_y0   (crop_y0),
    .crop_y1   (crop_y1),
    .stream    (stream),
    .running   (running),
    .frame_cnt (frame_cnt),
    .last_rows (last_rows),
    .err_ovf   (err_ovf),
    .err_beat  (err_beat)
  );

  // Each cycle: score any accepted word at the falling edge, then step past the rising edge.
  task automatic tick(input int n = 1);
    logic [OUT_W+1:0] got;
    logic [OUT_W+1:0] want;
    repeat (n) begin
      @(negedge pclk);
      if (rst_n && stream.dout_valid && stream.dout_ready) begin
        got = {stream.dout_sof, stream.dout_eol, stream.dout};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL word_unexpected got=%h required=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL word_data got=%h required=%h", got, want);
          end
        end
      end
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    href = 1'b0; vsync = 1'b1; din = '0; start = 1'b0; stop = 1'b0;
    stream.dout_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    exp_q.delete();
    tick(1);
  endtask

  task automatic set_crop(input int x0, input int x1, input int y0, input int y1);
    crop_x0 = CNT_W'(x0); crop_x1 = CNT_W'(x1);
    crop_y0 = CNT_W'(y0); crop_y1 = CNT_W'(y1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic frame_begin();
    vsync = 1'b0; tick(3);
  endtask

  task automatic frame_end();
    vsync = 1'b1; tick(4);
  endtask

  task automatic send_line(input logic [63:0] pw, input int nbeats);
    logic [15:0] p;
    for (int b = 0; b < nbeats; b++) begin
      p = pw[16*(b/2) +: 16];
      href = 1'b1;
      din = (b % 2 == 0) ? p[15:8] : p[7:0];
      tick(1);
    end
    href = 1'b0; din = '0;
    tick(3);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick(1);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({stream.dout_valid, running, err_ovf, err_beat} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got=%b required=0000", {stream.dout_valid, running, err_ovf, err_beat});
    end
    n_cmp++;
    if ({frame_cnt, last_rows, stream.dout} !== '0) begin
      n_bad++;
      $display("FAIL reset_counters got=%h/%h/%h required=0", frame_cnt, last_rows, stream.dout);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    set_crop(0, 3, 0, 1);
    pulse_start();
    n_cmp++;
    if (running !== 1'b1) begin n_bad++; $display("FAIL armed_running got=%b required=1", running); end
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, PW_A});
    send_line(PW_A, 8);
    exp_q.push_back({1'b0, 1'b1, PW_A});
    send_line(PW_A, 8);
    frame_end();
    wait_drain();
    n_cmp++;
    if (frame_cnt !== 32'd1) begin n_bad++; $display("FAIL basic_frame_cnt got=%0d required=1", frame_cnt); end
    n_cmp++;
    if (last_rows !== CNT_W'(2)) begin n_bad++; $display("FAIL basic_last_rows got=%0d required=2", last_rows); end
    n_cmp++;
    if ({err_ovf, err_beat} !== 2'b00) begin n_bad++; $display("FAIL basic_errs got=%b required=00", {err_ovf, err_beat}); end
  endtask

  task automatic test_crop();
    do_reset();
    set_crop(1, 2, 0, 1);
    pulse_start();
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, 64'h000000009ABC5678});
    send_line(PW_A, 8);
    frame_end();
    wait_drain();
    set_crop(5, 2, 0, 1);
    frame_begin();
    send_line(PW_A, 8);
    frame_end();
    tick(4);
    n_cmp++;
    if (frame_cnt !== 32'd2) begin n_bad++; $display("FAIL crop_frame_cnt got=%0d required=2", frame_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    set_crop(0, 3, 0, 3);
    stream.dout_ready = 1'b0;
    pulse_start();
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, PW_A});
    send_line(PW_A, 8);
    exp_q.push_back({1'b0, 1'b1, PW_B});
    send_line(PW_B, 8);
    send_line(PW_C, 8);
    frame_end();
    n_cmp++;
    if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b required=1", err_ovf); end
    n_cmp++;
    if ({stream.dout_valid, stream.dout} !== {1'b1, PW_A}) begin
      n_bad++;
      $display("FAIL ovf_head got=%b/%h required=1/%h", stream.dout_valid, stream.dout, PW_A);
    end
    stream.dout_ready = 1'b1;
    wait_drain();
    tick(3);
    n_cmp++;
    if (stream.dout_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got=%b required=0", stream.dout_valid); end
  endtask

  task automatic test_partial_beat();
    do_reset();
    set_crop(0, 3, 0, 1);
    pulse_start();
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, {16'h0000, PW_A[47:0]}});
    send_line(PW_A, 7);
    frame_end();
    wait_drain();
    n_cmp++;
    if (err_beat !== 1'b1) begin n_bad++; $display("FAIL beat_flag got=%b required=1", err_beat); end
  endtask

  task automatic test_stop();
    do_reset();
    set_crop(0, 3, 0, 0);
    pulse_start();
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, PW_A});
    send_line(PW_A, 8);
    frame_end();
    frame_begin();
    pulse_stop();
    n_cmp++;
    if (running !== 1'b1) begin n_bad++; $display("FAIL stopping_running got=%b required=1", running); end
    exp_q.push_back({1'b1, 1'b1, PW_B});
    send_line(PW_B, 8);
    frame_end();
    wait_drain();
    n_cmp++;
    if ({frame_cnt, running} !== {32'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL stop_done got=%0d/%b required=2/0", frame_cnt, running);
    end
    frame_begin();
    send_line(PW_C, 8);
    frame_end();
    tick(4);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(1);
    n_cmp++;
    if (running !== 1'b0) begin n_bad++; $display("FAIL start_stop_same got=%b required=0", running); end
    frame_begin();
    send_line(PW_C, 8);
    frame_end();
    tick(4);
    n_cmp++;
    if (frame_cnt !== 32'd2) begin n_bad++; $display("FAIL idle_frame_cnt got=%0d required=2", frame_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_crop(0, 3, 0, 3);
    pulse_start();
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, PW_A});
    send_line(PW_A, 8);
    frame_end();
    wait_drain();
    stream.dout_ready = 1'b0;
    frame_begin();
    send_line(PW_B, 8);
    n_cmp++;
    if ({stream.dout_valid, frame_cnt} !== {1'b1, 32'd1}) begin
      n_bad++;
      $display("FAIL prereset_state got=%b/%0d required=1/1", stream.dout_valid, frame_cnt);
    end
    for (int b = 0; b < 3; b++) begin
      href = 1'b1; din = 8'h55; tick(1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stream.dout_valid, frame_cnt} !== {1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL async_reset got=%b/%0d required=0/0", stream.dout_valid, frame_cnt);
    end
    href = 1'b0; vsync = 1'b1; din = '0;
    tick(2);
    rst_n = 1'b1;
    stream.dout_ready = 1'b1;
    tick(1);
    pulse_start();
    frame_begin();
    exp_q.push_back({1'b1, 1'b1, PW_C});
    send_line(PW_C, 8);
    frame_end();
    wait_drain();
    n_cmp++;
    if (frame_cnt !== 32'd1) begin n_bad++; $display("FAIL post_reset_frame got=%0d required=1", frame_cnt); end
  endtask

  initial begin
    stream.dout_ready = 1'b1;
    test_reset();
    test_basic_frame();
    test_crop();
    test_overflow();
    test_partial_beat();
    test_stop();
    test_async_reset();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
